// File: rtl/bscan_pkg.sv
// Shared frame layout for the JTAG user-register channel bridge.
// Default payload/tag widths and the frame struct used at both FIFOs.
package bscan_pkg;

  localparam int BSCAN_WIDTH  = 32;
  localparam int BSCAN_CHAN_W = 2;
  localparam int FRAME_W      = 1 + BSCAN_CHAN_W + BSCAN_WIDTH;
  localparam int VALID_BIT    = 0;

  typedef struct packed {
    logic [BSCAN_WIDTH-1:0]  data;
    logic [BSCAN_CHAN_W-1:0] chan;
  } bscan_frame_t;

endpackage

// File: rtl/bscan_chan_fifo_bridge_if.sv
// Tagged-frame enq handshake between the bridge and core logic.
// master drives the frame and ENA, slave answers with RDY.
interface bscan_chan_fifo_bridge_if #(
  parameter int WIDTH  = 32,
  parameter int CHAN_W = 2
);

  logic              enq__ENA;
  logic [WIDTH-1:0]  enq_v;
  logic [CHAN_W-1:0] enq_chan;
  logic              enq__RDY;

  modport master (
    output enq__ENA,
    output enq_v,
    output enq_chan,
    input  enq__RDY
  );

  modport slave (
    input  enq__ENA,
    input  enq_v,
    input  enq_chan,
    output enq__RDY
  );

endinterface

// File: rtl/bscan_sync_fifo.sv
// Power-of-two synchronous FIFO with wrap-bit pointers.
// enq and deq may fire in the same cycle, including when full.
module bscan_sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         enq,
  input  logic [W-1:0] din,
  input  logic         deq,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty,
  output logic [AW:0]  level
);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wp;
  logic [AW:0]  rp;

  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (enq) wp <= wp + (AW+1)'(1);
      if (deq) rp <= rp + (AW+1)'(1);
    end
  end

  // a full-FIFO write lands on the head slot only after it was read out
  always_ff @(posedge clk) begin
    if (enq) mem[wp[AW-1:0]] <= din;
  end

  assign dout  = mem[rp[AW-1:0]];
  assign level = wp - rp;
  assign empty = (wp == rp);
  assign full  = (level == (AW+1)'(DEPTH));

endmodule

// File: rtl/bscan_chan_fifo_bridge.sv
// JTAG user-DR bridge: scan register plus tx/rx frame FIFOs.
// Outbound head is popped only at update, so an aborted scan loses nothing.
module bscan_chan_fifo_bridge
  import bscan_pkg::*;
#(
  parameter int WIDTH  = BSCAN_WIDTH,
  parameter int CHAN_W = BSCAN_CHAN_W,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 8,
  localparam int PW    = CHAN_W + WIDTH,
  localparam int FW    = 1 + PW,
  localparam int LW    = $clog2(DEPTH) + 1
) (
  input  logic                     CLK,
  input  logic                     RST,
  bscan_chan_fifo_bridge_if.slave  toBscan,
  bscan_chan_fifo_bridge_if.master fromBscan,
  input  logic                     capture,
  input  logic                     shift,
  input  logic                     update,
  input  logic                     TDI,
  output logic                     TDO,
  output logic [LW-1:0]            tx_level,
  output logic [CNT_W-1:0]         ovf_count
);

  logic [FW-1:0] sr;
  logic          pend_pop;
  logic          do_cap, do_sh, do_up;

  logic [PW-1:0] tx_head, rx_head;
  logic          tx_full, tx_empty, tx_enq, tx_deq;
  logic          rx_full, rx_empty, rx_enq, rx_deq;
  logic          push_req, drop;
  logic [LW-1:0] rx_level;
  logic          unused_rx;

  assign do_cap = capture;
  assign do_sh  = shift & ~capture;
  assign do_up  = update & ~capture & ~shift;

  assign toBscan.enq__RDY = ~tx_full & ~RST;
  assign tx_enq = toBscan.enq__ENA & toBscan.enq__RDY;
  assign tx_deq = do_up & pend_pop;

  assign push_req = do_up & sr[VALID_BIT];
  assign rx_deq   = ~rx_empty & fromBscan.enq__RDY;
  assign rx_enq   = push_req & (~rx_full | rx_deq);
  assign drop     = push_req & rx_full & ~rx_deq;

  assign fromBscan.enq__ENA = rx_deq;
  assign fromBscan.enq_v    = rx_head[PW-1:CHAN_W];
  assign fromBscan.enq_chan = rx_head[CHAN_W-1:0];

  assign TDO       = sr[VALID_BIT];
  assign unused_rx = ^rx_level;

  always_ff @(posedge CLK) begin
    if (RST) begin
      sr <= '0;
    end else if (do_cap) begin
      sr <= tx_empty ? '0 : {tx_head, 1'b1};
    end else if (do_sh) begin
      sr <= {TDI, sr[FW-1:1]};
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      pend_pop <= 1'b0;
    end else if (do_cap) begin
      pend_pop <= ~tx_empty;
    end else if (do_up) begin
      pend_pop <= 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      ovf_count <= '0;
    end else if (drop && ovf_count != '1) begin
      ovf_count <= ovf_count + CNT_W'(1);
    end
  end

  bscan_sync_fifo #(.W(PW), .DEPTH(DEPTH)) u_tx (
    .clk   (CLK),
    .rst   (RST),
    .enq   (tx_enq),
    .din   ({toBscan.enq_v, toBscan.enq_chan}),
    .deq   (tx_deq),
    .dout  (tx_head),
    .full  (tx_full),
    .empty (tx_empty),
    .level (tx_level)
  );

  bscan_sync_fifo #(.W(PW), .DEPTH(DEPTH)) u_rx (
    .clk   (CLK),
    .rst   (RST),
    .enq   (rx_enq),
    .din   (sr[FW-1:1]),
    .deq   (rx_deq),
    .dout  (rx_head),
    .full  (rx_full),
    .empty (rx_empty),
    .level (rx_level)
  );

endmodule

// File: tb/tb_bscan_chan_fifo_bridge.sv
// Directed bench for the JTAG channel FIFO bridge.
// Hand-computed frames, levels and drop counts.
module tb_bscan_chan_fifo_bridge;
  import bscan_pkg::*;

  logic       CLK = 1'b0;
  logic       RST;
  logic       capture, shift, update, TDI;
  logic       TDO;
  logic [2:0] tx_level;
  logic [7:0] ovf_count;

  int checks = 0;
  int errors = 0;

  bscan_chan_fifo_bridge_if #(.WIDTH(32), .CHAN_W(2)) to_if ();
  bscan_chan_fifo_bridge_if #(.WIDTH(32), .CHAN_W(2)) from_if ();

  bscan_chan_fifo_bridge #(
    .WIDTH(32), .CHAN_W(2), .DEPTH(4), .CNT_W(8)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .toBscan   (to_if),
    .fromBscan (from_if),
    .capture   (capture),
    .shift     (shift),
    .update    (update),
    .TDI       (TDI),
    .TDO       (TDO),
    .tx_level  (tx_level),
    .ovf_count (ovf_count)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [FRAME_W-1:0] frm(input logic [31:0] v,
                                             input logic [1:0] c);
    bscan_frame_t f;
    f.data = v;
    f.chan = c;
    return {f, 1'b1};
  endfunction

  task automatic enq(input logic [31:0] v, input logic [1:0] c);
    to_if.enq__ENA = 1'b1;
    to_if.enq_v    = v;
    to_if.enq_chan = c;
    step();
    to_if.enq__ENA = 1'b0;
  endtask

  task automatic cap();
    capture = 1'b1;
    step();
    capture = 1'b0;
  endtask

  task automatic upd();
    update = 1'b1;
    step();
    update = 1'b0;
  endtask

  task automatic scan(input logic [FRAME_W-1:0] tin,
                      output logic [FRAME_W-1:0] tout);
    for (int i = 0; i < FRAME_W; i++) begin
      tout[i] = TDO;
      TDI     = tin[i];
      shift   = 1'b1;
      step();
    end
    shift = 1'b0;
    TDI   = 1'b0;
  endtask

  logic [FRAME_W-1:0] tdo_bits;
  int n;

  initial begin
    RST = 1'b1;
    capture = 0; shift = 0; update = 0; TDI = 0;
    to_if.enq__ENA = 0; to_if.enq_v = '0; to_if.enq_chan = '0;
    from_if.enq__RDY = 1'b1;

    // reset state
    step(); step();
    chk("rst_rdy_low", to_if.enq__RDY, 0);
    chk("rst_tdo", TDO, 0);
    chk("rst_level", tx_level, 0);
    chk("rst_ena", from_if.enq__ENA, 0);
    chk("rst_ovf", ovf_count, 0);
    RST = 1'b0;
    #1;
    chk("rst_rdy_high", to_if.enq__RDY, 1);

    // loopback
    enq(32'hDEADBEEF, 2'd2);
    chk("lb_level1", tx_level, 1);
    cap();
    scan(frm(32'hDEADBEEF, 2'd2), tdo_bits);
    chk("lb_tdo_stream", tdo_bits, 35'h6_F56D_F77D);
    chk("lb_level_pre_upd", tx_level, 1);
    upd();
    chk("lb_level0", tx_level, 0);
    chk("lb_ena", from_if.enq__ENA, 1);
    chk("lb_v", from_if.enq_v, 32'hDEADBEEF);
    chk("lb_chan", from_if.enq_chan, 2);
    step();
    chk("lb_ena_after", from_if.enq__ENA, 0);

    // idle frame
    cap();
    chk("idle_tdo", TDO, 0);
    scan('0, tdo_bits);
    chk("idle_stream", tdo_bits, 0);
    upd();
    chk("idle_ena", from_if.enq__ENA, 0);
    chk("idle_ovf", ovf_count, 0);

    // aborted scan: recapture re-presents, reset clears
    enq(32'h11111111, 2'd1);
    cap();
    chk("abort_tdo1", TDO, 1);
    cap();
    chk("abort_recap_tdo", TDO, 1);
    chk("abort_recap_level", tx_level, 1);
    RST = 1'b1;
    step();
    RST = 1'b0;
    #1;
    chk("abort_rst_level", tx_level, 0);
    chk("abort_rst_tdo", TDO, 0);

    // capture wins over update
    enq(32'hCAFEF00D, 2'd3);
    cap();
    capture = 1'b1; update = 1'b1;
    step();
    capture = 1'b0; update = 1'b0;
    chk("prio_level", tx_level, 1);
    chk("prio_no_push", from_if.enq__ENA, 0);
    upd();
    chk("prio_upd_level", tx_level, 0);
    chk("prio_upd_ena", from_if.enq__ENA, 1);
    chk("prio_upd_v", from_if.enq_v, 32'hCAFEF00D);
    chk("prio_upd_chan", from_if.enq_chan, 3);
    step();
    chk("prio_drained", from_if.enq__ENA, 0);

    // overflow: sr still holds the valid CAFEF00D frame
    from_if.enq__RDY = 1'b0;
    update = 1'b1;
    repeat (6) step();
    update = 1'b0;
    chk("ovf_two", ovf_count, 2);
    from_if.enq__RDY = 1'b1;
    update = 1'b1;
    #1;
    chk("full_simul_ena", from_if.enq__ENA, 1);
    step();
    update = 1'b0;
    chk("full_simul_nodrop", ovf_count, 2);
    n = 0;
    for (int i = 0; i < 6; i++) begin
      #1;
      if (from_if.enq__ENA === 1'b1) n++;
      step();
    end
    chk("rx_drain_count", n, 4);
    from_if.enq__RDY = 1'b0;
    update = 1'b1;
    repeat (302) step();
    update = 1'b0;
    chk("ovf_saturate", ovf_count, 255);
    from_if.enq__RDY = 1'b1;
    repeat (6) step();

    // tx full, refused enq alongside update-pop
    enq(32'h000000A0, 2'd0);
    cap();
    enq(32'h000000A1, 2'd1);
    enq(32'h000000A2, 2'd2);
    enq(32'h000000A3, 2'd3);
    chk("txfull_level", tx_level, 4);
    chk("txfull_rdy", to_if.enq__RDY, 0);
    to_if.enq__ENA = 1'b1;
    to_if.enq_v = 32'h000000A4;
    to_if.enq_chan = 2'd0;
    update = 1'b1;
    step();
    update = 1'b0;
    to_if.enq__ENA = 1'b0;
    chk("txfull_refused", tx_level, 3);
    cap();
    to_if.enq__ENA = 1'b1;
    update = 1'b1;
    step();
    update = 1'b0;
    to_if.enq__ENA = 1'b0;
    chk("tx_enq_pop_level", tx_level, 3);
    cap();
    scan('0, tdo_bits);
    chk("tx_order_head", tdo_bits, frm(32'h000000A2, 2'd2));
    chk("tx_cap_no_pop", tx_level, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
